// File: rtl/mips_mem_pkg.sv
// Shared constants and decode types for the CPU data-side memory responder.
// Holds the MMIO register offsets, the default address map and the region decode enum.
package mips_mem_pkg;

    localparam logic [3:0] MMIO_CYCLE   = 4'h0;
    localparam logic [3:0] MMIO_SCRATCH = 4'h4;
    localparam logic [3:0] MMIO_STATUS  = 4'h8;
    localparam logic [3:0] MMIO_RSVD    = 4'hC;

    localparam logic [31:0] DEFAULT_RAM_BASE  = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_t;

endpackage

// File: rtl/mips_mmio_regs.sv
// MMIO block: free-running CYCLE counter, SCRATCH register, STATUS with the sticky bus-error latch.
// Reads are combinational; writes and error capture take effect at the clock edge; clk_enable low freezes all state.
module mips_mmio_regs
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        mmio_wr,
    input  logic [1:0]  reg_sel,
    input  logic [31:0] wdata,
    input  logic        err_set,
    output logic [31:0] rdata,
    output logic        bus_error,
    output logic [31:0] cycle_count
);

    logic [31:0] cycle_q;
    logic [31:0] scratch_q;
    logic        err_q;
    logic        scratch_we;
    logic        status_clr;

    assign scratch_we = mmio_wr && (reg_sel == MMIO_SCRATCH[3:2]);
    assign status_clr = mmio_wr && (reg_sel == MMIO_STATUS[3:2]) && wdata[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= 32'd0;
            scratch_q <= 32'd0;
            err_q     <= 1'b0;
        end else if (clk_enable) begin
            cycle_q <= cycle_q + 32'd1;
            if (scratch_we) begin
                scratch_q <= wdata;
            end
            // A new error in the same cycle as a software clear must not be lost.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (status_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            MMIO_CYCLE[3:2]:   rdata = cycle_q;
            MMIO_SCRATCH[3:2]: rdata = scratch_q;
            MMIO_STATUS[3:2]:  rdata = {31'd0, err_q};
            default:           rdata = 32'd0;
        endcase
    end

    assign bus_error   = err_q;
    assign cycle_count = cycle_q;

endmodule

// File: rtl/mips_data_mem.sv
// Data-port responder: word RAM window plus MMIO block, with unmapped/misaligned access flagging.
// Zero-latency combinational read, write commits at the next enabled edge; no backpressure, clk_enable stalls everything.
module mips_data_mem
    import mips_mem_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] RAM_BASE  = DEFAULT_RAM_BASE,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        bus_error,
    output logic [31:0] cycle_count
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int HI    = ADDR_BITS + 2;

    logic [31:0]          mem [0:DEPTH-1];
    region_t              region;
    logic [ADDR_BITS-1:0] index;
    logic                 misaligned;
    logic                 err_set;
    logic                 mmio_wr;
    logic                 ram_we;
    logic [31:0]          mmio_rdata;

    // RAM_BASE is aligned to the window size, so a tag compare is the range check.
    always_comb begin
        region = REGION_NONE;
        if (data_address[31:HI] == RAM_BASE[31:HI]) begin
            region = REGION_RAM;
        end else if (data_address[31:4] == MMIO_BASE[31:4]) begin
            region = REGION_MMIO;
        end
    end

    assign index      = data_address[HI-1:2];
    assign misaligned = |data_address[1:0];
    assign err_set    = (data_read || data_write) && ((region == REGION_NONE) || misaligned);
    assign mmio_wr    = data_write && !misaligned && (region == REGION_MMIO);
    assign ram_we     = clk_enable && data_write && !misaligned && (region == REGION_RAM);

    // RAM is not reset; sampling reset here drops a write pending when reset arrives.
    always_ff @(posedge clk) begin
        if (reset && ram_we) begin
            mem[index] <= data_writedata;
        end
    end

    mips_mmio_regs u_mmio (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .mmio_wr     (mmio_wr),
        .reg_sel     (data_address[3:2]),
        .wdata       (data_writedata),
        .err_set     (err_set),
        .rdata       (mmio_rdata),
        .bus_error   (bus_error),
        .cycle_count (cycle_count)
    );

    always_comb begin
        data_readdata = 32'd0;
        if (data_read) begin
            case (region)
                REGION_RAM:  data_readdata = mem[index];
                REGION_MMIO: data_readdata = mmio_rdata;
                default:     data_readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed plus randomized bench for mips_data_mem against an address-map reference model.
module tb_mips_data_mem;

    localparam logic [31:0] RB = 32'h0000_1000;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        bus_error;
    logic [31:0] cycle_count;

    int checks;
    int failures;

    logic [31:0] m_mem [0:1023];
    logic [31:0] m_cyc;
    logic [31:0] m_scr;
    logic        m_err;

    mips_data_mem dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata),
        .bus_error      (bus_error),
        .cycle_count    (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= RB) && (a < RB + 32'd4096);
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return (a >> 4) == (MB >> 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
        logic [31:0] w;
        if (!rd) return 32'd0;
        if (in_ram(a)) begin
            w = (a - RB) >> 2;
            return m_mem[w[9:0]];
        end
        if (in_mmio(a)) begin
            case ((a & 32'hF) >> 2)
                0: return m_cyc;
                1: return m_scr;
                2: return {31'd0, m_err};
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] wd, input logic en);
        data_address   = a;
        data_read      = rd;
        data_write     = wr;
        data_writedata = wd;
        clk_enable     = en;
        #1;
    endtask

    // Advance the model by the effect of one edge with the current inputs, then clock the DUT.
    task automatic tick();
        logic [31:0] a;
        logic [31:0] w;
        bit mis, set, clr;
        a = data_address;
        if (clk_enable) begin
            m_cyc = m_cyc + 32'd1;
            mis = (a[1:0] != 2'd0);
            set = (data_read || data_write) && ((!in_ram(a) && !in_mmio(a)) || mis);
            clr = 1'b0;
            if (data_write && !mis) begin
                if (in_ram(a)) begin
                    w = (a - RB) >> 2;
                    m_mem[w[9:0]] = data_writedata;
                end else if (in_mmio(a)) begin
                    if (a[3:0] == 4'h4) m_scr = data_writedata;
                    if (a[3:0] == 4'h8 && data_writedata[0]) clr = 1'b1;
                end
            end
            if (set) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_cycle"}, cycle_count, m_cyc);
        chk({tag, "_berr"}, {31'd0, bus_error}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_cyc = 32'd0;
        m_scr = 32'd0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_cyc    = 32'd0;
        m_scr    = 32'd0;
        m_err    = 1'b0;
        reset    = 1'b0;
        drive(RB, 1'b0, 1'b0, 32'd0, 1'b1);

        // Reset state
        chk("rst_cycle", cycle_count, 32'd0);
        chk("rst_berr", {31'd0, bus_error}, 32'd0);
        chk("rst_rdata", data_readdata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Preload and readback
        drive(RB, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        tick();
        drive(RB + 32'd8, 1'b0, 1'b1, 32'h1111_1111, 1'b1);
        tick();
        drive(RB, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("preload_rd", data_readdata, 32'hDEAD_BEEF);
        chk("preload_berr", {31'd0, bus_error}, 32'd0);
        chk_state("preload");

        // Read-during-write returns the old word
        drive(RB + 32'd8, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
        chk("rdw_old", data_readdata, 32'h1111_1111);
        tick();
        drive(RB + 32'd8, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("rdw_new", data_readdata, 32'h1234_5678);
        drive(RB + 32'd8, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0);
        tick();
        drive(RB + 32'd8, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("stall_wr", data_readdata, 32'h1234_5678);
        chk_state("stall_wr");

        // Cycle counting with stalls, then wrap
        do_reset();
        drive(RB, 1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        drive(RB, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        drive(MB + {28'd0, 4'h0}, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("cyc10", data_readdata, 32'd10);
        chk("cyc10_port", cycle_count, m_cyc);
        drive(RB, 1'b0, 1'b0, 32'd0, 1'b1);
        force dut.u_mmio.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_mmio.cycle_q;
        m_cyc = 32'hFFFF_FFFF;
        chk("cyc_max", cycle_count, 32'hFFFF_FFFF);
        tick();
        chk("cyc_wrap", cycle_count, 32'd0);

        // Unmapped access, status clear, set-wins
        drive(32'h0000_0000, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("unmapped_rd", data_readdata, 32'd0);
        tick();
        chk("berr_set", {31'd0, bus_error}, 32'd1);
        drive(MB + 32'h8, 1'b0, 1'b1, 32'd1, 1'b1);
        tick();
        chk("berr_clr", {31'd0, bus_error}, 32'd0);
        drive(32'h0000_0000, 1'b0, 1'b1, 32'd0, 1'b1);
        tick();
        drive(MB + 32'h9, 1'b0, 1'b1, 32'd1, 1'b1);
        tick();
        chk("berr_setwins", {31'd0, bus_error}, 32'd1);
        chk_state("berr");

        // SCRATCH and read-only CYCLE
        drive(MB + 32'h4, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1);
        tick();
        drive(MB + 32'h4, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("scratch", data_readdata, 32'hA5A5_0001);
        drive(MB, 1'b0, 1'b1, 32'd0, 1'b1);
        tick();
        drive(MB, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("cyc_ro", data_readdata, m_cyc);
        chk("cyc_ro_nz", {31'd0, data_readdata > 32'd3}, 32'd1);

        // Asynchronous reset with a write pending
        drive(RB, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1);
        #2;
        reset = 1'b0;
        m_cyc = 32'd0;
        m_scr = 32'd0;
        m_err = 1'b0;
        #1;
        chk("arst_cycle", cycle_count, 32'd0);
        chk("arst_berr", {31'd0, bus_error}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(RB, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("arst_ram0", data_readdata, 32'hDEAD_BEEF);
        drive(RB + 32'd8, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("arst_ram8", data_readdata, 32'h1234_5678);
        drive(MB + 32'h4, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("arst_scratch", data_readdata, 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) begin
            drive(RB + 32'(4 * i), 1'b0, 1'b1, $urandom, 1'b1);
            tick();
        end
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [31:0] um [4];
            um[0] = 32'h0000_0000;
            um[1] = RB - 32'd4;
            um[2] = RB + 32'd4096;
            um[3] = MB + 32'h10;
            case ($urandom_range(0, 3))
                0, 1: begin
                    a = RB + 32'(4 * $urandom_range(0, 15));
                    if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
                end
                2: a = MB + 32'($urandom_range(0, 15));
                default: a = um[$urandom_range(0, 3)];
            endcase
            drive(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom,
                  1'($urandom_range(0, 7) != 0));
            chk("rand_rd", data_readdata, model_read(data_address, data_read));
            tick();
            chk_state("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
